rgb_frame_loader: RTL and testbench
===================================

Name: rgb_frame_loader

Overview:
- Sequences the UART receive datapath into the VGA frame RAM.
- Consumes the byte stream from uart_rx (`o_Rx_DV`/`o_Rx_Byte`) and waits for a sync byte.
- Then packs every R,G,B byte triplet into one 12-bit pixel and drives the frame RAM write port with an auto-incrementing address.
- Sits between UART_RX_INST and the frame RAM whose read port belongs to vga_controller; reports frame completion and stream errors.

Parameters:
- H_RES, 160, pixels per line.
- V_RES, 120, lines per frame.
- ADDR_W, 15, frame RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- SYNC_BYTE, 8'hAA, start-of-frame marker.
- TIMEOUT_CLKS, 520800, max idle clocks between bytes inside a frame (10 byte-times at 9600 baud, 50 MHz).

Ports:
- i_Clock  input  1  system clock, 50 MHz.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte valid.
- i_Rx_Byte  input  8  received byte.
- o_Wr_En  output  1  frame RAM write strobe, one cycle.
- o_Wr_Addr  output  ADDR_W  frame RAM write address.
- o_Wr_Data  output  12  pixel {R[7:4],G[7:4],B[7:4]}.
- o_Busy  output  1  high while a frame is being loaded (state != IDLE).
- o_Frame_Done  output  1  one-cycle pulse after last pixel write.
- o_Frame_Err  output  1  one-cycle pulse on timeout (or checksum mismatch, see option).
- o_Led  output  1  toggles on every o_Frame_Done.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. Every register is reset on i_Reset=1 at a rising edge.
- Reset values:
  - state=IDLE.
  - o_Wr_En, o_Frame_Done and o_Frame_Err = 0.
  - o_Wr_Addr=0, o_Wr_Data=0, o_Busy=0, o_Led=0.
  - Timeout counter=0.
- IDLE:
  - Ignore every byte except SYNC_BYTE.
  - On i_Rx_DV with SYNC_BYTE: go to GET_R, clear address to 0, clear timeout counter.
- GET_R / GET_G / GET_B:
  - On i_Rx_DV, latch the byte's upper nibble into the R/G/B pixel field and advance GET_R->GET_G->GET_B.
  - On the DV in GET_B, next cycle: o_Wr_En=1, o_Wr_Data=packed pixel, o_Wr_Addr=current address.
  - Address and data are held stable while o_Wr_En=1. Write latency is 1 clock from the B-byte DV.
  - After the write, the address increments by 1.
  - If the written address was H_RES*V_RES-1: go to DONE. Otherwise go to GET_R.
- Sync byte mid-frame: a SYNC_BYTE value received in GET_* states is pixel data, not a resync.
- DONE: lasts exactly one cycle. It pulses o_Frame_Done, toggles o_Led, resets the address to 0, then goes to IDLE.
- Timeout counter:
  - Counts clocks in GET_* states and clears on each i_Rx_DV.
  - On reaching TIMEOUT_CLKS-1 without DV: pulse o_Frame_Err, go to IDLE, address=0, partial pixel discarded, no write.
  - Already-written pixels remain in RAM.
- o_Busy: o_Busy=1 in GET_* and DONE.
- Simultaneous events:
  - i_Reset wins over everything.
  - i_Rx_DV in the same cycle the timeout expires: the byte wins and the counter clears.
  - A DV coinciding with the o_Wr_En cycle is processed normally as the next R byte. The state is already GET_R, so no byte is lost.
- Reset mid-frame: immediate return to IDLE on the next edge. No o_Frame_Done or o_Frame_Err is generated.
- Widths: address compare uses ADDR_W bits. H_RES*V_RES is computed as an ADDR_W+1-bit constant.

Optional Feature:
- Macro: RGB_FRAME_LOADER_CHECKSUM_EN.
- Defined:
  - After the last pixel, go to GET_CSUM instead of DONE.
  - The next byte is compared with the running XOR of all R,G,B bytes of the frame (sync byte excluded).
  - Match -> DONE (o_Frame_Done pulse).
  - Mismatch -> o_Frame_Err pulse, no o_Led toggle, IDLE.
  - The timeout also applies in GET_CSUM.
- Undefined: no checksum byte; the last pixel write goes directly to DONE; no XOR register.

Decomposition:
- Shared package/header (rgb_pkg.vh): state encodings, SYNC_BYTE default, PIX_W=12, pixel pack function/macro.
- One natural sub-module: inactivity_timer (counter with clear/enable/expire pulse), reusable by the VGA reset logic.
- Everything else is in rgb_frame_loader.

Test Plan:
- Reset then send 8'h55, 8'hAA, 8'hF0, 8'h80, 8'h1F -> the first byte is ignored; exactly one write with o_Wr_Addr=0, o_Wr_Data=12'hF81, o_Wr_En high one cycle, 1 clock after the last DV.
- Full frame with H_RES=4, V_RES=2: sync + 24 bytes -> 8 writes at addresses 0..7 in order, then o_Frame_Done one cycle later, o_Led=1, o_Busy=0.
- Sync + R,G bytes, then silence for TIMEOUT_CLKS (override 100) -> o_Frame_Err pulse at cycle 100, no write, state IDLE; the next frame starts at address 0.
- Send 8'hAA as a G byte mid-frame -> treated as data, pixel G nibble=4'hA, no resync.
- Assert i_Reset during the 3rd pixel -> outputs return to reset values on the next edge, no Done/Err pulse.
- CHECKSUM_EN, 2x1 frame bytes 01,02,03,04,05,06: checksum 8'h07 -> Done; checksum 8'h00 -> Err, o_Led unchanged.

Source files
------------

// File: rtl/rgb_frame_loader_pkg.sv
// rgb_frame_loader_pkg: shared state encoding, sync default and pixel packing for the UART-to-frame-RAM loader
package rgb_frame_loader_pkg;
    localparam int PIX_W = 12;
    localparam logic [7:0] SYNC_DEFAULT = 8'hAA;
    typedef enum logic [2:0] {IDLE, GET_R, GET_G, GET_B, DONE, GET_CSUM} state_t;
    function automatic logic [PIX_W-1:0] pack_pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {r, g, b};
    endfunction
endpackage

// File: rtl/rgb_frame_loader_inactivity_timer.sv
// rgb_frame_loader_inactivity_timer: counts enabled idle clocks, pulses expire on the LIMIT-th clock without clr
module rgb_frame_loader_inactivity_timer #(
    parameter int LIMIT = 520800
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam int CW = $clog2(LIMIT);
    logic [CW-1:0] count;
    assign expire = en && !clr && count == CW'(LIMIT - 1);
    always_ff @(posedge clk)
        count <= (rst || clr || !en || expire) ? '0 : count + 1'b1;
endmodule

// File: rtl/rgb_frame_loader.sv
// rgb_frame_loader: sync-triggered R,G,B byte packer writing 12-bit pixels to frame RAM; RGB_FRAME_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module rgb_frame_loader
    import rgb_frame_loader_pkg::*;
#(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int ADDR_W = 15,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int TIMEOUT_CLKS = 520800
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [PIX_W-1:0]  o_Wr_Data,
    output logic              o_Busy,
    output logic              o_Frame_Done,
    output logic              o_Frame_Err,
    output logic              o_Led
);
    localparam logic [ADDR_W:0] PIXELS = (ADDR_W + 1)'(H_RES * V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1'b1);
`ifdef RGB_FRAME_LOADER_CHECKSUM_EN
    localparam state_t LAST_NEXT = GET_CSUM;
`else
    localparam state_t LAST_NEXT = DONE;
`endif
    state_t state, state_d;
    logic wr_d, done_d, err_d, expire, last;
    logic [3:0] r_nib, g_nib;
    assign o_Busy = state != IDLE;
    assign last = o_Wr_Addr == LAST_ADDR;
    rgb_frame_loader_inactivity_timer #(.LIMIT(TIMEOUT_CLKS)) u_timer (
        .clk(i_Clock),
        .rst(i_Reset),
        .en(state inside {GET_R, GET_G, GET_B, GET_CSUM}),
        .clr(i_Rx_DV),
        .expire(expire)
    );
`ifdef RGB_FRAME_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic csum_ok;
    assign csum_ok = i_Rx_Byte == csum;
    always_ff @(posedge i_Clock)
        csum <= (i_Reset || state == IDLE) ? '0 :
                (i_Rx_DV && state inside {GET_R, GET_G, GET_B}) ? csum ^ i_Rx_Byte : csum;
`endif
    always_comb begin
        state_d = state;
        wr_d = 1'b0;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state)
            IDLE:  state_d = (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) ? GET_R : IDLE;
            GET_R: state_d = i_Rx_DV ? GET_G : GET_R;
            GET_G: state_d = i_Rx_DV ? GET_B : GET_G;
            GET_B: begin
                wr_d = i_Rx_DV;
                state_d = i_Rx_DV ? (last ? LAST_NEXT : GET_R) : GET_B;
            end
`ifdef RGB_FRAME_LOADER_CHECKSUM_EN
            GET_CSUM: begin
                err_d = i_Rx_DV && !csum_ok;
                state_d = i_Rx_DV ? (csum_ok ? DONE : IDLE) : GET_CSUM;
            end
`endif
            DONE: begin
                done_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // expire is already masked by a same-cycle byte, so the byte wins
        if (expire) begin
            err_d = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
            o_Wr_En <= 1'b0;
            o_Wr_Addr <= '0;
            o_Wr_Data <= '0;
            o_Frame_Done <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Led <= 1'b0;
            r_nib <= '0;
            g_nib <= '0;
        end else begin
            state <= state_d;
            o_Wr_En <= wr_d;
            o_Frame_Done <= done_d;
            o_Frame_Err <= err_d;
            o_Led <= o_Led ^ done_d;
            o_Wr_Addr <= (state_d == IDLE) ? '0 : o_Wr_Addr + ADDR_W'(o_Wr_En);
            if (i_Rx_DV && state == GET_R) r_nib <= i_Rx_Byte[7:4];
            if (i_Rx_DV && state == GET_G) g_nib <= i_Rx_Byte[7:4];
            if (wr_d) o_Wr_Data <= pack_pixel(r_nib, g_nib, i_Rx_Byte[7:4]);
        end
    end
endmodule

// File: tb/tb_rgb_frame_loader.sv
// tb_rgb_frame_loader: directed vectors for a 4x2 frame with a 100-clock timeout
module tb_rgb_frame_loader;
    logic clk = 1'b0, rst = 1'b1, dv = 1'b0;
    logic [7:0] rx = 8'h00;
    logic wr_en, busy, done, err, led;
    logic [2:0] addr;
    logic [11:0] data;
    int n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0, n_err = 0;
    logic [2:0] wa_q[$];
    logic [11:0] wd_q[$];
    typedef struct {logic [7:0] r, g, b; logic [11:0] px;} vec_t;
    vec_t v[8];
    rgb_frame_loader #(
        .H_RES(4), .V_RES(2), .ADDR_W(3), .SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(100)
    ) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx),
        .o_Wr_En(wr_en), .o_Wr_Addr(addr), .o_Wr_Data(data), .o_Busy(busy),
        .o_Frame_Done(done), .o_Frame_Err(err), .o_Led(led)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        #1;
        if (wr_en) begin
            n_wr++;
            wa_q.push_back(addr);
            wd_q.push_back(data);
        end
        if (done) n_done++;
        if (err) n_err++;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b);
        dv = 1'b1;
        rx = b;
        @(negedge clk);
        dv = 1'b0;
    endtask
    task automatic clr_log();
        n_wr = 0;
        n_done = 0;
        n_err = 0;
        wa_q.delete();
        wd_q.delete();
    endtask
    task automatic send_frame(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'h00;
        send(8'hAA);
        for (int i = 0; i < 8; i++) begin
            send(v[i].r);
            send(v[i].g);
            send(v[i].b);
            x = x ^ v[i].r ^ v[i].g ^ v[i].b;
        end
`ifdef RGB_FRAME_LOADER_CHECKSUM_EN
        send(x ^ flip);
`else
        if (flip != 8'h00) $display("note: checksum flip %0h has no effect in this build, xor %0h", flip, x);
`endif
        idle(1);
    endtask
    initial begin
        v[0] = '{8'hF0, 8'h80, 8'h1F, 12'hF81};
        v[1] = '{8'h12, 8'h34, 8'h56, 12'h135};
        v[2] = '{8'h30, 8'hAA, 8'hC0, 12'h3AC};
        v[3] = '{8'hFF, 8'hFF, 8'hFF, 12'hFFF};
        v[4] = '{8'h00, 8'h00, 8'h00, 12'h000};
        v[5] = '{8'h7E, 8'h81, 8'h4B, 12'h784};
        v[6] = '{8'hAA, 8'h55, 8'hAA, 12'hA5A};
        v[7] = '{8'h09, 8'hE3, 8'hD7, 12'h0ED};
        idle(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_led", led, 0);
        rst = 1'b0;
        idle(1);
        clr_log();
        send(8'h55);
        check("non_sync_ignored", busy, 0);
        send(8'hAA);
        check("sync_busy", busy, 1);
        send(8'hF0);
        send(8'h80);
        send(8'h1F);
        check("px_wr_en", wr_en, 1);
        check("px_addr", addr, 0);
        check("px_data", data, 12'hF81);
        idle(1);
        check("px_wr_pulse", wr_en, 0);
        check("px_wr_count", n_wr, 1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clr_log();
        send_frame(8'h00);
        check("frame_done", done, 1);
        check("frame_led", led, 1);
        check("frame_busy", busy, 0);
        check("frame_wr_count", n_wr, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("frame_addr%0d", i), (wa_q.size() > i) ? 32'(wa_q[i]) : 32'hDEAD, i);
            check($sformatf("frame_data%0d", i), (wd_q.size() > i) ? 32'(wd_q[i]) : 32'hDEAD, v[i].px);
        end
        idle(1);
        check("done_pulse", done, 0);
        check("done_count", n_done, 1);
        check("frame_err_none", n_err, 0);
`ifdef RGB_FRAME_LOADER_CHECKSUM_EN
        clr_log();
        send_frame(8'hFF);
        check("csum_bad_err", err, 1);
        check("csum_bad_done", n_done, 0);
        check("csum_bad_led", led, 1);
`endif
        clr_log();
        send(8'hAA);
        for (int i = 0; i < 2; i++) begin
            send(v[i].r);
            send(v[i].g);
            send(v[i].b);
        end
        send(v[2].r);
        send(v[2].g);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_addr", addr, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_led", led, 0);
        rst = 1'b0;
        idle(3);
        check("mid_rst_done", n_done, 0);
        check("mid_rst_err", n_err, 0);
        check("mid_rst_writes", n_wr, 2);
        clr_log();
        send(8'hAA);
        send(8'h12);
        send(8'h34);
        idle(99);
        check("to_early_err", err, 0);
        check("to_early_busy", busy, 1);
        idle(1);
        check("to_err", err, 1);
        check("to_idle", busy, 0);
        idle(1);
        check("to_err_pulse", err, 0);
        check("to_no_write", n_wr, 0);
        send(8'hAA);
        send(8'h51);
        send(8'h62);
        send(8'h73);
        check("after_to_addr", addr, 0);
        check("after_to_data", data, 12'h567);
        send(8'hC4);
        idle(99);
        send(8'hD5);
        check("dv_wins_err", err, 0);
        check("dv_wins_busy", busy, 1);
        send(8'hE6);
        check("dv_wins_wr", wr_en, 1);
        check("dv_wins_addr", addr, 1);
        check("dv_wins_data", data, 12'hCDE);
        idle(2);
        check("to_err_count", n_err, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
